// File: rtl/fan_ramp_scheduler.sv
// Fan speed sequencer: latches the requested level and walks the applied level toward it
// one step per STEP_CYCLES. The optional auto-off timer is built when FAN_OFF_TIMER_EN is defined.
module fan_ramp_scheduler #(
  parameter int unsigned STEP_CYCLES       = 20_000_000,
  parameter int unsigned TIMER_UNIT_CYCLES = 100_000_000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [4:0] i_button,
  input  logic       i_timer,
  output logic [2:0] o_fanState,
  output logic [2:0] o_target,
  output logic       o_busy,
  output logic [1:0] o_timer_sel
);

  localparam int unsigned StepW = $clog2(STEP_CYCLES);
  localparam logic [StepW-1:0] StepLast = StepW'(STEP_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StRampUp, StRampDown} state_e;

  state_e           state_q, state_d;
  logic [2:0]       cur_q, cur_d;
  logic [2:0]       tgt_q, tgt_d;
  logic [StepW-1:0] step_q, step_d;
  logic             busy_q, busy_d;

  logic       off_btn;
  logic       req_vld;
  logic [2:0] req_lvl;
  logic       timer_off;

  // Button decode: bit 0 is off; otherwise the highest speed bit wins.
  always_comb begin
    off_btn = i_button[0];
    req_vld = |i_button[4:1];
    if (i_button[4])      req_lvl = 3'd4;
    else if (i_button[3]) req_lvl = 3'd3;
    else if (i_button[2]) req_lvl = 3'd2;
    else if (i_button[1]) req_lvl = 3'd1;
    else                  req_lvl = 3'd0;
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q <= StIdle;
      cur_q   <= 3'd0;
      tgt_q   <= 3'd0;
      step_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      tgt_q   <= tgt_d;
      step_q  <= step_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic
  always_comb begin
    logic   off_req;
    logic   new_req;
    state_e dir;

    state_d = state_q;
    cur_d   = cur_q;
    tgt_d   = tgt_q;
    step_d  = step_q;
    dir     = StIdle;
    off_req = off_btn | timer_off;
    new_req = !off_req && req_vld && (req_lvl != tgt_q);

    if (off_req) begin
      tgt_d   = 3'd0;
      cur_d   = 3'd0;
      step_d  = '0;
      state_d = StIdle;
    end else begin
      if (new_req) tgt_d = req_lvl;

      if (new_req && (cur_q == 3'd0)) begin
        // Kick-start: spin up to level 1 immediately, then ramp from there.
        cur_d   = 3'd1;
        step_d  = '0;
        state_d = (req_lvl == 3'd1) ? StIdle : StRampUp;
      end else if (cur_q == tgt_d) begin
        state_d = StIdle;
        step_d  = '0;
      end else begin
        dir = (cur_q < tgt_d) ? StRampUp : StRampDown;
        if (state_q != dir) begin
          // Entry or reversal restarts the interval; same-direction retargets keep it.
          state_d = dir;
          step_d  = '0;
        end else if (step_q == StepLast) begin
          cur_d   = (dir == StRampUp) ? cur_q + 3'd1 : cur_q - 3'd1;
          step_d  = '0;
          state_d = (cur_d == tgt_d) ? StIdle : dir;
        end else begin
          step_d  = step_q + StepW'(1);
          state_d = dir;
        end
      end
    end

    busy_d = (state_d != StIdle);
  end

  // Outputs
  always_comb begin
    o_fanState = cur_q;
    o_target   = tgt_q;
    o_busy     = busy_q;
  end

`ifdef FAN_OFF_TIMER_EN
  localparam int unsigned TimerW = $clog2(3 * TIMER_UNIT_CYCLES + 1);

  logic [1:0]        sel_q, sel_d;
  logic [1:0]        sel_new;
  logic [TimerW-1:0] tcnt_q, tcnt_d;

  assign timer_off = (sel_q != 2'd0) && (tcnt_q == TimerW'(1));

  always_comb begin
    sel_d   = sel_q;
    tcnt_d  = tcnt_q;
    sel_new = sel_q + 2'd1;
    if (off_btn || timer_off) begin
      sel_d  = 2'd0;
      tcnt_d = '0;
    end else if (i_timer) begin
      sel_d  = sel_new;
      tcnt_d = TimerW'(sel_new) * TimerW'(TIMER_UNIT_CYCLES);
    end else if ((sel_q != 2'd0) && (tgt_q != 3'd0) && (tcnt_q != '0)) begin
      tcnt_d = tcnt_q - TimerW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      sel_q  <= 2'd0;
      tcnt_q <= '0;
    end else begin
      sel_q  <= sel_d;
      tcnt_q <= tcnt_d;
    end
  end

  assign o_timer_sel = sel_q;
`else
  logic        unused_timer;
  logic [31:0] unused_timer_unit;

  assign unused_timer      = i_timer;
  assign unused_timer_unit = TIMER_UNIT_CYCLES;
  assign timer_off         = 1'b0;
  assign o_timer_sel       = 2'd0;
`endif

endmodule

// File: tb/tb_fan_ramp_scheduler.sv
// Scoreboard bench for fan_ramp_scheduler (STEP_CYCLES=4, TIMER_UNIT_CYCLES=10).
module tb_fan_ramp_scheduler;

  typedef struct packed {
    logic [2:0] fan;
    logic [2:0] tgt;
    logic       busy;
    logic [1:0] sel;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] button = 5'd0;
  logic       timer = 1'b0;
  logic [2:0] fan_state;
  logic [2:0] target;
  logic       busy;
  logic [1:0] timer_sel;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  fan_ramp_scheduler #(
    .STEP_CYCLES      (4),
    .TIMER_UNIT_CYCLES(10)
  ) dut (
    .i_clk      (clk),
    .i_reset    (rst_n),
    .i_button   (button),
    .i_timer    (timer),
    .o_fanState (fan_state),
    .o_target   (target),
    .o_busy     (busy),
    .o_timer_sel(timer_sel)
  );

  // Drive inputs for one edge, then record what the outputs must be after it.
  task automatic cyc(input logic [4:0] b, input logic t, input logic [2:0] f,
                     input logic [2:0] g, input logic bz, input logic [1:0] s);
    exp_t e;
    button = b;
    timer  = t;
    @(posedge clk);
    #1;
    e.fan  = f;
    e.tgt  = g;
    e.busy = bz;
    e.sel  = s;
    exp_q.push_back(e);
    button = 5'd0;
    timer  = 1'b0;
  endtask

  task automatic hold(input int n, input logic [2:0] f, input logic [2:0] g,
                      input logic bz, input logic [1:0] s);
    for (int i = 0; i < n; i++) cyc(5'd0, 1'b0, f, g, bz, s);
  endtask

  // Monitor: pops one expectation per edge it was issued for.
  initial begin
    exp_t e;
    exp_t a;
    forever begin
      @(posedge clk);
      #3;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {fan_state, target, busy, timer_sel};
        n_vec++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL vec%0d @%0t: fan=%0d tgt=%0d busy=%0b sel=%0d, need fan=%0d tgt=%0d busy=%0b sel=%0d",
                   n_vec, $time, a.fan, a.tgt, a.busy, a.sel, e.fan, e.tgt, e.busy, e.sel);
        end
      end
    end
  end

  initial begin
    int sel2;
`ifdef FAN_OFF_TIMER_EN
    sel2 = 2;
`else
    sel2 = 0;
`endif
    // Reset
    hold(2, 3'd0, 3'd0, 1'b0, 2'd0);
    rst_n = 1'b1;
    hold(1, 3'd0, 3'd0, 1'b0, 2'd0);

    // 1: kick-start to 1, ramp to 3
    cyc(5'b01000, 1'b0, 3'd1, 3'd3, 1'b1, 2'd0);
    hold(3, 3'd1, 3'd3, 1'b1, 2'd0);
    cyc(5'd0, 1'b0, 3'd2, 3'd3, 1'b1, 2'd0);
    hold(3, 3'd2, 3'd3, 1'b1, 2'd0);
    cyc(5'd0, 1'b0, 3'd3, 3'd3, 1'b0, 2'd0);

    // 2: up to 4, then ramp down to 1
    cyc(5'b10000, 1'b0, 3'd3, 3'd4, 1'b1, 2'd0);
    hold(3, 3'd3, 3'd4, 1'b1, 2'd0);
    cyc(5'd0, 1'b0, 3'd4, 3'd4, 1'b0, 2'd0);
    cyc(5'b00010, 1'b0, 3'd4, 3'd1, 1'b1, 2'd0);
    hold(3, 3'd4, 3'd1, 1'b1, 2'd0);
    cyc(5'd0, 1'b0, 3'd3, 3'd1, 1'b1, 2'd0);
    hold(3, 3'd3, 3'd1, 1'b1, 2'd0);
    cyc(5'd0, 1'b0, 3'd2, 3'd1, 1'b1, 2'd0);
    hold(3, 3'd2, 3'd1, 1'b1, 2'd0);
    cyc(5'd0, 1'b0, 3'd1, 3'd1, 1'b0, 2'd0);
    // Request for current target is a no-op
    cyc(5'b00010, 1'b0, 3'd1, 3'd1, 1'b0, 2'd0);

    // 3: off mid ramp-up at level 2
    cyc(5'b10000, 1'b0, 3'd1, 3'd4, 1'b1, 2'd0);
    hold(3, 3'd1, 3'd4, 1'b1, 2'd0);
    cyc(5'd0, 1'b0, 3'd2, 3'd4, 1'b1, 2'd0);
    hold(1, 3'd2, 3'd4, 1'b1, 2'd0);
    cyc(5'b00001, 1'b0, 3'd0, 3'd0, 1'b0, 2'd0);
    hold(2, 3'd0, 3'd0, 1'b0, 2'd0);

    // 4: highest bit wins, off bit wins over all
    cyc(5'b11010, 1'b0, 3'd1, 3'd4, 1'b1, 2'd0);
    cyc(5'b00011, 1'b0, 3'd0, 3'd0, 1'b0, 2'd0);

    // 5: reversal at cur=2 with counter at 2 clears the counter
    cyc(5'b10000, 1'b0, 3'd1, 3'd4, 1'b1, 2'd0);
    hold(3, 3'd1, 3'd4, 1'b1, 2'd0);
    cyc(5'd0, 1'b0, 3'd2, 3'd4, 1'b1, 2'd0);
    hold(2, 3'd2, 3'd4, 1'b1, 2'd0);
    cyc(5'b00010, 1'b0, 3'd2, 3'd1, 1'b1, 2'd0);
    hold(3, 3'd2, 3'd1, 1'b1, 2'd0);
    cyc(5'd0, 1'b0, 3'd1, 3'd1, 1'b0, 2'd0);

    // 6: auto-off timer at level 2
    cyc(5'b00100, 1'b0, 3'd1, 3'd2, 1'b1, 2'd0);
    hold(3, 3'd1, 3'd2, 1'b1, 2'd0);
    cyc(5'd0, 1'b0, 3'd2, 3'd2, 1'b0, 2'd0);
    cyc(5'd0, 1'b1, 3'd2, 3'd2, 1'b0, 2'(sel2 / 2));
    cyc(5'd0, 1'b1, 3'd2, 3'd2, 1'b0, 2'(sel2));
    if (sel2 != 0) begin
      hold(19, 3'd2, 3'd2, 1'b0, 2'd2);
      cyc(5'd0, 1'b0, 3'd0, 3'd0, 1'b0, 2'd0);
    end else begin
      hold(20, 3'd2, 3'd2, 1'b0, 2'd0);
      cyc(5'b00001, 1'b0, 3'd0, 3'd0, 1'b0, 2'd0);
    end

    // Reset asserted mid-ramp
    cyc(5'b10000, 1'b0, 3'd1, 3'd4, 1'b1, 2'd0);
    hold(2, 3'd1, 3'd4, 1'b1, 2'd0);
    rst_n = 1'b0;
    hold(1, 3'd0, 3'd0, 1'b0, 2'd0);
    rst_n = 1'b1;
    hold(2, 3'd0, 3'd0, 1'b0, 2'd0);

    // Drain the scoreboard with a bound
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #5;
    if (exp_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, need 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
